// File: rtl/codificador_pkg.sv
// Shared types and helpers for the registered 4-to-2 encoder: FSM states,
// the idle pin pattern and the active-low line encoding functions.
package codificador_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ATIVO  = 2'd1,
        ERRO   = 2'd2
    } estado_t;

    localparam logic [3:0] IDLE_PATTERN = 4'b1111;

    // Highest-index low line wins, so a single zero gets its plain code
    // and the same function serves the priority build.
    function automatic logic [1:0] codifica(input logic [3:0] p);
        if (!p[3])      return 2'd3;
        else if (!p[2]) return 2'd2;
        else if (!p[1]) return 2'd1;
        else            return 2'd0;
    endfunction

    function automatic logic multiplos_zeros(input logic [3:0] p);
        int unsigned zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!p[i]) zeros++;
        end
        return zeros > 1;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to all ones so
// that idle active-low lines never look asserted coming out of reset.
module sincronizador_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            // NOTE: non-blocking assignments make both stages sample on the same edge; blocking would collapse them into one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/codificador_4_2_sinc.sv
// Registered, debounced 4-to-2 encoder for active-low select lines.
// Define CODIFICADOR_PRIORIDADE_EN to encode multi-zero patterns by priority instead of flagging erro.
module codificador_4_2_sinc
    import codificador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic N3,
    input  logic N2,
    input  logic N1,
    input  logic N0,
    output logic A,
    output logic B,
    output logic valido,
    output logic strobe,
    output logic erro
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       p;
    logic [3:0]       p_prev;
    logic [CNT_W-1:0] cnt;
    logic             estavel;

    estado_t          estado, estado_prox;
    logic             carrega;
    logic [1:0]       codigo;
    logic [1:0]       ab_q;
    logic             valido_q, strobe_q, erro_q;
    logic             padrao_ocioso, padrao_valido, padrao_erro;

    sincronizador_2ff #(.W(4)) u_sincronizador (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({N3, N2, N1, N0}),
        .q     (p)
    );

    // The counter keeps running while en is low so re-enabling sees the true pin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_prev <= IDLE_PATTERN;
            cnt    <= '0;
        end else begin
            p_prev <= p;
            if (p != p_prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign estavel       = (p == p_prev) && (cnt == CNT_MAX);
    assign padrao_ocioso = (p == IDLE_PATTERN);
    assign codigo        = codifica(p);

`ifdef CODIFICADOR_PRIORIDADE_EN
    assign padrao_erro   = 1'b0;
    assign padrao_valido = !padrao_ocioso;
`else
    assign padrao_erro   = multiplos_zeros(p);
    assign padrao_valido = !padrao_ocioso && !padrao_erro;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        estado_prox = estado;
        carrega     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (estavel && padrao_valido) begin
                    estado_prox = ATIVO;
                    carrega     = 1'b1;
                end else if (estavel && padrao_erro) begin
                    estado_prox = ERRO;
                end
            end
            ATIVO: begin
                if (estavel && padrao_ocioso)
                    estado_prox = OCIOSO;
                else if (estavel && padrao_erro)
                    estado_prox = ERRO;
                else if (estavel && padrao_valido && (codigo != ab_q))
                    carrega = 1'b1;
            end
            ERRO: begin
                if (estavel && padrao_ocioso) begin
                    estado_prox = OCIOSO;
                end else if (estavel && padrao_valido) begin
                    estado_prox = ATIVO;
                    carrega     = 1'b1;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
        if (!en) begin
            estado_prox = OCIOSO;
            carrega     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            ab_q     <= 2'b00;
            valido_q <= 1'b0;
            strobe_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado   <= estado_prox;
            strobe_q <= carrega;
            valido_q <= (estado_prox == ATIVO);
`ifdef CODIFICADOR_PRIORIDADE_EN
            erro_q   <= 1'b0;
`else
            erro_q   <= (estado_prox == ERRO);
`endif
            if (carrega)
                ab_q <= codigo;
        end
    end

    assign A      = ab_q[1];
    assign B      = ab_q[0];
    assign valido = valido_q;
    assign strobe = strobe_q;
    assign erro   = erro_q;

endmodule

// File: tb/tb_codificador_4_2_sinc.sv
// Self-checking bench for codificador_4_2_sinc with DEBOUNCE_CYCLES=4;
// expectations follow CODIFICADOR_PRIORIDADE_EN when it is defined.
module tb_codificador_4_2_sinc;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n, en;
    logic [3:0] n;
    logic a, b, valido, strobe, erro;

    int total = 0, passed = 0;
    int strobes = 0, viol_strobe = 0, viol_flags = 0;
    logic strobe_ant = 1'b0;

    codificador_4_2_sinc #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .N3     (n[3]),
        .N2     (n[2]),
        .N1     (n[1]),
        .N0     (n[0]),
        .A      (a),
        .B      (b),
        .valido (valido),
        .strobe (strobe),
        .erro   (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nome;
        logic [3:0] n;
        int         ciclos;
        logic [1:0] ab;
        logic       val;
        logic       err;
        int         strobes;
    } vetor_t;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    endtask

    task automatic tick(input int ciclos);
        for (int i = 0; i < ciclos; i++) begin
            @(posedge clk);
            #1;
            if (strobe) strobes++;
            if (strobe && strobe_ant) viol_strobe++;
            if (valido && erro) viol_flags++;
            strobe_ant = strobe;
        end
    endtask

    task automatic check_saidas(input string nome, input logic [1:0] ab, input logic val, input logic err);
        check({nome, ".ab"},     {a, b},  ab);
        check({nome, ".valido"}, valido,  val);
        check({nome, ".erro"},   erro,    err);
    endtask

    vetor_t tabela[8];

    initial begin
        tabela[0] = '{"solta_n2",  4'b1111, 20, 2'b10, 1'b0, 1'b0, 0};
        tabela[1] = '{"n3",        4'b0111, 20, 2'b11, 1'b1, 1'b0, 1};
        tabela[2] = '{"n1_reload", 4'b1101, 20, 2'b01, 1'b1, 1'b0, 1};
`ifdef CODIFICADOR_PRIORIDADE_EN
        tabela[3] = '{"n3_n0",     4'b0110, 20, 2'b11, 1'b1, 1'b0, 1};
`else
        tabela[3] = '{"n3_n0",     4'b0110, 20, 2'b01, 1'b0, 1'b1, 0};
`endif
        tabela[4] = '{"n0",        4'b1110, 20, 2'b00, 1'b1, 1'b0, 1};
        tabela[5] = '{"solta_n0",  4'b1111, 20, 2'b00, 1'b0, 1'b0, 0};
        tabela[6] = '{"n0_denovo", 4'b1110, 20, 2'b00, 1'b1, 1'b0, 1};
        tabela[7] = '{"solta_fim", 4'b1111, 20, 2'b00, 1'b0, 1'b0, 0};

        rst_n = 1'b0;
        en    = 1'b1;
        n     = 4'b1111;
        tick(3);
        check_saidas("reset", 2'b00, 1'b0, 1'b0);
        check("reset.strobe", strobe, 1'b0);
        rst_n = 1'b1;

        strobes = 0;
        tick(100);
        check("idle.strobes", strobes, 0);
        check_saidas("idle", 2'b00, 1'b0, 1'b0);

        // Pins change right after an edge (cycle 0); strobe must appear at cycle D+3 only.
        strobes = 0;
        n = 4'b1011;
        tick(D + 2);
        check("latencia.antes", strobes, 0);
        tick(1);
        check("latencia.strobe", strobe, 1'b1);
        check_saidas("latencia", 2'b10, 1'b1, 1'b0);
        tick(10);
        check("latencia.unico", strobes, 1);
        check("latencia.valido", valido, 1'b1);

        for (int i = 0; i < 8; i++) begin
            strobes = 0;
            n = tabela[i].n;
            tick(tabela[i].ciclos);
            check({tabela[i].nome, ".strobes"}, strobes, tabela[i].strobes);
            check_saidas(tabela[i].nome, tabela[i].ab, tabela[i].val, tabela[i].err);
        end

        // N1 bouncing: never stable long enough to be accepted.
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            n = (i % 3 == 2) ? 4'b1111 : 4'b1101;
            tick(1);
        end
        check("bounce.strobes", strobes, 0);
        check("bounce.valido", valido, 1'b0);
        n = 4'b1101;
        tick(20);
        check("bounce_fim.strobes", strobes, 1);
        check_saidas("bounce_fim", 2'b01, 1'b1, 1'b0);

        // en dropped while ATIVO: flags clear on the next edge, code holds.
        strobes = 0;
        en = 1'b0;
        tick(1);
        check_saidas("en_baixo", 2'b01, 1'b0, 1'b0);
        check("en_baixo.strobe", strobe, 1'b0);
        tick(10);
        n = 4'b1111;
        tick(10);
        en = 1'b1;
        tick(10);
        check("en_volta.strobes", strobes, 0);
        check("en_volta.valido", valido, 1'b0);
        n = 4'b1011;
        tick(20);
        check("en_nova.strobes", strobes, 1);
        check_saidas("en_nova", 2'b10, 1'b1, 1'b0);

        // Reset in the middle of filtering a new press.
        n = 4'b1111;
        tick(20);
        strobes = 0;
        n = 4'b0111;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_saidas("reset_meio", 2'b00, 1'b0, 1'b0);
        check("reset_meio.strobe", strobe, 1'b0);
        n = 4'b1111;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("pos_reset.strobes", strobes, 0);
        check("pos_reset.valido", valido, 1'b0);
        n = 4'b0111;
        tick(20);
        check("pos_reset_nova.strobes", strobes, 1);
        check_saidas("pos_reset_nova", 2'b11, 1'b1, 1'b0);

        check("strobe_consecutivo", viol_strobe, 0);
        check("valido_e_erro", viol_flags, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/codificador_4_2_sinc.md
Name: codificador_4_2_sinc

Overview:
- Registered 4-to-2 encoder: the inverse of the team's active-low 2-to-4 decoder.
- Takes four asynchronous active-low select lines (e.g. buttons, or another board's decoder outputs), synchronises and debounces them, and encodes the single active line into {A,B}.
- Provides a level "valid" flag, a one-cycle strobe per new code, and an error flag when more than one line is low.
- Sits between FPGA pins and control logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a pattern is accepted; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the stability counter; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  synchronous enable; low forces the idle state.
- N3  input  1  active-low line 3, asynchronous.
- N2  input  1  active-low line 2, asynchronous.
- N1  input  1  active-low line 1, asynchronous.
- N0  input  1  active-low line 0, asynchronous.
- A  output  1  code MSB, registered.
- B  output  1  code LSB, registered.
- valido  output  1  high while an accepted single-line code is present.
- strobe  output  1  one-cycle pulse when a new code is accepted.
- erro  output  1  high while an accepted multi-line pattern is present.

Behaviour:
- Reset (rst_n low, async):
  - synchroniser flops = 4'b1111; previous-sample register = 4'b1111; counter = 0; FSM = OCIOSO.
  - A=0, B=0, valido=0, strobe=0, erro=0.
- Synchroniser: two flops per line. p = second-stage value {N3,N2,N1,N0}; p_prev = p delayed one cycle.
- Stability counter:
  - p != p_prev: cnt <= 0.
  - p == p_prev: cnt <= cnt+1, saturating at DEBOUNCE_CYCLES-1.
  - stable = (p == p_prev) && (cnt == DEBOUNCE_CYCLES-1).
- Encoding when exactly one bit of p is 0: N0 -> {A,B}=00, N1 -> 01, N2 -> 10, N3 -> 11.
- FSM states: OCIOSO, ATIVO, ERRO.
  - OCIOSO:
    - stable, exactly one zero -> ATIVO; load {A,B}, valido=1, strobe=1 for that cycle.
    - stable, two or more zeros -> ERRO; erro=1.
    - stable, p==1111 -> remain.
  - ATIVO:
    - stable, p==1111 -> OCIOSO; valido=0. A,B hold their last value.
    - stable, different single-zero pattern -> reload {A,B}, strobe=1, stay in ATIVO.
    - stable, multi-zero -> ERRO; valido=0, erro=1.
  - ERRO:
    - stable, p==1111 -> OCIOSO; erro=0.
    - stable, single-zero -> ATIVO; load code, strobe=1, erro=0.
- en low: next state OCIOSO; valido=0, erro=0, strobe=0; counter keeps running. A,B hold.
- Latency: pins change at cycle 0 and are held → strobe high at cycle DEBOUNCE_CYCLES+3.
- Glitch filtering: any bounce shorter than DEBOUNCE_CYCLES resets the counter and produces no output change.
- Strobe timing: strobe is never high two consecutive cycles. The same code re-accepted without passing through 1111 or ERRO does not strobe again.
- valido and erro are never high simultaneously.
- Reset mid-filtering discards the partial count; no strobe follows reset.

Optional Feature:
- Macro: CODIFICADOR_PRIORIDADE_EN.
- Defined: a stable multi-zero pattern is not an error. It encodes the highest-index low line (N3 > N2 > N1 > N0) and behaves exactly like a single-zero pattern. The ERRO state is unreachable and erro is tied 0.
- Undefined: behaviour exactly as above.

Decomposition:
- Package codificador_pkg:
  - FSM state enum (OCIOSO=2'd0, ATIVO=2'd1, ERRO=2'd2).
  - IDLE_PATTERN = 4'b1111.
  - One-hot-low-to-code function.
- Sub-module sincronizador_2ff (parameterised width, reset value 1): instantiate once with width 4. Reusable for other pin inputs.

Test Plan:
- Reset, then hold N=1111 for 100 cycles -> valido=0, strobe never pulses, A=B=0.
- DEBOUNCE_CYCLES=4; drive N2 low at cycle 0 and hold -> strobe=1 only at cycle 7, A=1, B=0, valido stays 1.
- N1 low bouncing high every 3 cycles for 30 cycles, with DEBOUNCE_CYCLES=4 -> no strobe. Then hold N1 low -> strobe once, {A,B}=01.
- N3 and N0 low together, held -> erro=1, valido=0, no strobe. With the macro: {A,B}=11, valido=1, strobe once.
- ATIVO on N0; release all; after debounce press N0 again -> valido drops then rises, two strobes total.
- Assert rst_n low mid-count, and separately drop en in ATIVO -> all flags 0 immediately (reset) or next cycle (en). No strobe afterward until a fresh stable press.
